// File: rtl/pipeline_mult_arbiter_if.sv
// Bundles the requester, multiplier and result signals of the shared-multiplier arbiter.
// The arbiter is the slave side; the surrounding system (requesters, multiplier, sink) is the master side.
interface pipeline_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;

    logic [3:0]           mul_a;
    logic [3:0]           mul_b;
    logic                 mul_en;
    logic [7:0]           mul_y;

    logic                 res_valid;
    logic [7:0]           res_data;
    logic [ID_W-1:0]      res_id;
    logic                 res_ready;

    logic                 drain_req;
    logic                 drained;
    logic [ID_W:0]        inflight;

    modport master (
        output req_valid, req_a, req_b, mul_y, res_ready, drain_req,
        input  req_ready, mul_a, mul_b, mul_en, res_valid, res_data, res_id,
               drained, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_y, res_ready, drain_req,
        output req_ready, mul_a, mul_b, mul_en, res_valid, res_data, res_id,
               drained, inflight
    );
endinterface

// File: rtl/pipeline_mult_arbiter.sv
// Round-robin arbiter sharing one enable-gated 4x4 pipelined multiplier among NUM_REQ requesters,
// with a requester-ID shadow pipeline, result back-pressure and a drain mode.
module pipeline_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_mult_arbiter_if.slave bus
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     rr_ptr_next;
    logic [LATENCY:1]    v_reg;
    logic [ID_W-1:0]     id_reg [1:LATENCY];

    logic                stall;
    logic                advance;
    logic                issue;
    logic                any_hit;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W:0]       inflight_cnt;

    logic [ID_W:0]       cand_sum [NUM_REQ];
    logic [ID_W-1:0]     cand     [NUM_REQ];
    logic [NUM_REQ-1:0]  hit;

    // Candidate gi is the requester gi places after rr_ptr, wrapped into 0..NUM_REQ-1.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
            assign cand[gi]     = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                                ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                                : cand_sum[gi][ID_W-1:0];
            assign hit[gi]      = bus.req_valid[cand[gi]];
        end
    endgenerate

    always_comb begin
        any_hit  = 1'b0;
        grant_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit  = 1'b1;
                grant_id = cand[i];
            end
        end
    end

    assign stall   = v_reg[LATENCY] & ~bus.res_ready;
    assign advance = ~stall;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (bus.drain_req)  state_next = ST_DRAIN;
            ST_DRAIN: if (!bus.drain_req) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // Output logic; reset also gates issue so no grant is shown while reset is held.
    always_comb begin
        issue       = reset & (state_reg == ST_RUN) & ~bus.drain_req & advance & any_hit;
        bus.drained = (state_reg == ST_DRAIN) & (inflight_cnt == '0);
    end

    always_comb begin
        bus.req_ready = '0;
        bus.mul_a     = 4'd0;
        bus.mul_b     = 4'd0;
        if (issue) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.mul_a = bus.req_a[{grant_id, 2'b00} +: 4];
            bus.mul_b = bus.req_b[{grant_id, 2'b00} +: 4];
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (issue) begin
            rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Shadow tags move only on the edges where the multiplier itself advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_reg <= '0;
            for (int k = 1; k <= LATENCY; k++) begin
                id_reg[k] <= '0;
            end
        end else if (advance) begin
            for (int k = LATENCY; k >= 2; k--) begin
                v_reg[k]  <= v_reg[k-1];
                id_reg[k] <= id_reg[k-1];
            end
            v_reg[1]  <= issue;
            id_reg[1] <= grant_id;
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int k = 1; k <= LATENCY; k++) begin
            inflight_cnt = inflight_cnt + (ID_W+1)'(v_reg[k]);
        end
    end

    assign bus.inflight  = inflight_cnt;
    assign bus.mul_en    = advance;
    assign bus.res_valid = v_reg[LATENCY];
    assign bus.res_id    = id_reg[LATENCY];
    assign bus.res_data  = bus.mul_y;

endmodule
